// File: rtl/cordic_share_arb.sv
// Round-robin front end that shares one fixed-latency CORDIC rotator among NCH requesters,
// carrying each operation's channel tag alongside the CORDIC pipeline and strobing results back.
module cordic_share_arb #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int BW         = 16,
    parameter int ZW         = 24,
    parameter int CORDIC_LAT = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hold,
    input  logic [NCH-1:0]     req_valid,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH*BW-1:0]  req_x,
    input  logic [NCH*BW-1:0]  req_y,
    input  logic [NCH*ZW-1:0]  req_z,
    output logic [BW-1:0]      cordic_xi,
    output logic [BW-1:0]      cordic_yi,
    output logic [ZW-1:0]      cordic_zi,
    input  logic [BW-1:0]      cordic_xo,
    input  logic [BW-1:0]      cordic_yo,
    input  logic [ZW-1:0]      cordic_zo,
    output logic               res_valid,
    output logic [CHW-1:0]     res_chan,
    output logic [BW-1:0]      res_x,
    output logic [BW-1:0]      res_y,
    output logic [ZW-1:0]      res_z,
    output logic               busy
);

    localparam int TP_DEPTH = 1 + CORDIC_LAT;

    logic [BW-1:0] chan_x [NCH];
    logic [BW-1:0] chan_y [NCH];
    logic [ZW-1:0] chan_z [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign chan_x[gi] = req_x[gi*BW +: BW];
            assign chan_y[gi] = req_y[gi*BW +: BW];
            assign chan_z[gi] = req_z[gi*ZW +: ZW];
        end
    endgenerate

    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0] grant_chan;
    logic           transfer;
    logic [CHW:0]   search_sum;
    logic [CHW-1:0] search_idx;

    // Scan from rr_ptr upward with wrap; the first valid channel found wins.
    always_comb begin
        transfer   = 1'b0;
        grant_chan = '0;
        search_sum = '0;
        search_idx = '0;
        if (!hold) begin
            for (int k = 0; k < NCH; k++) begin
                search_sum = {1'b0, rr_ptr_q} + (CHW+1)'(k);
                if (search_sum >= (CHW+1)'(NCH)) begin
                    search_sum = search_sum - (CHW+1)'(NCH);
                end
                search_idx = search_sum[CHW-1:0];
                if (!transfer && req_valid[search_idx]) begin
                    transfer   = 1'b1;
                    grant_chan = search_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            req_ready[k] = transfer && (grant_chan == CHW'(k));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (grant_chan == CHW'(NCH-1)) ? '0 : grant_chan + CHW'(1);
        end
    end

    logic [BW-1:0] cordic_xi_q, cordic_xi_d;
    logic [BW-1:0] cordic_yi_q, cordic_yi_d;
    logic [ZW-1:0] cordic_zi_q, cordic_zi_d;

    // Operand registers only load on a transfer so the CORDIC inputs stay quiet when idle.
    always_comb begin
        cordic_xi_d = cordic_xi_q;
        cordic_yi_d = cordic_yi_q;
        cordic_zi_d = cordic_zi_q;
        if (transfer) begin
            cordic_xi_d = chan_x[grant_chan];
            cordic_yi_d = chan_y[grant_chan];
            cordic_zi_d = chan_z[grant_chan];
        end
    end

    logic [TP_DEPTH-1:0] tag_valid_q, tag_valid_d;
    logic [CHW-1:0]      tag_chan_q [TP_DEPTH];
    logic [CHW-1:0]      tag_chan_d [TP_DEPTH];

    always_comb begin
        tag_valid_d = {tag_valid_q[TP_DEPTH-2:0], transfer};
    end

    assign tag_chan_d[0] = grant_chan;
    generate
        for (genvar gi = 1; gi < TP_DEPTH; gi++) begin : g_tag_shift
            assign tag_chan_d[gi] = tag_chan_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cordic_xi_q <= '0;
            cordic_yi_q <= '0;
            cordic_zi_q <= '0;
            tag_valid_q <= '0;
            for (int s = 0; s < TP_DEPTH; s++) begin
                tag_chan_q[s] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cordic_xi_q <= cordic_xi_d;
            cordic_yi_q <= cordic_yi_d;
            cordic_zi_q <= cordic_zi_d;
            tag_valid_q <= tag_valid_d;
            for (int s = 0; s < TP_DEPTH; s++) begin
                tag_chan_q[s] <= tag_chan_d[s];
            end
        end
    end

    assign cordic_xi = cordic_xi_q;
    assign cordic_yi = cordic_yi_q;
    assign cordic_zi = cordic_zi_q;

    // Results come straight off the CORDIC; the tag pipe supplies ownership and the strobe.
    assign res_valid = tag_valid_q[TP_DEPTH-1];
    assign res_chan  = tag_chan_q[TP_DEPTH-1];
    assign res_x     = cordic_xo;
    assign res_y     = cordic_yo;
    assign res_z     = cordic_zo;
    assign busy      = |tag_valid_q;

endmodule

// File: tb/tb_cordic_share_arb.sv
// Bench for cordic_share_arb: directed stimulus pushes expected results into a scoreboard,
// a negedge monitor pops and compares each res_valid strobe against a behavioural CORDIC.
module tb_cordic_share_arb;

    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int BW   = 16;
    localparam int ZW   = 24;
    localparam int LAT  = 21;
    localparam int PIPE = 1 + LAT;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              hold  = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH*BW-1:0] req_x, req_y;
    logic [NCH*ZW-1:0] req_z;
    logic [BW-1:0]     cordic_xi, cordic_yi, cordic_xo, cordic_yo;
    logic [ZW-1:0]     cordic_zi, cordic_zo;
    logic              res_valid, busy;
    logic [CHW-1:0]    res_chan;
    logic [BW-1:0]     res_x, res_y;
    logic [ZW-1:0]     res_z;

    cordic_share_arb #(.NCH(NCH), .CHW(CHW), .BW(BW), .ZW(ZW), .CORDIC_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .cordic_xi(cordic_xi), .cordic_yi(cordic_yi), .cordic_zi(cordic_zi),
        .cordic_xo(cordic_xo), .cordic_yo(cordic_yo), .cordic_zo(cordic_zo),
        .res_valid(res_valid), .res_chan(res_chan),
        .res_x(res_x), .res_y(res_y), .res_z(res_z), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cyc);
    endtask

    // Ideal rotation with CORDIC gain/2; residual phase replaced by the input phase.
    function automatic logic [BW-1:0] rot(input logic [BW-1:0] x, input logic [BW-1:0] y,
                                          input logic [ZW-1:0] z, input bit want_y);
        real a, xs, ys, r;
        a  = real'(z) * 6.283185307179586 / 16777216.0;
        xs = real'($signed(x));
        ys = real'($signed(y));
        if (want_y) r = 0.82338 * (xs * $sin(a) + ys * $cos(a));
        else        r = 0.82338 * (xs * $cos(a) - ys * $sin(a));
        return BW'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
    endfunction

    logic [BW-1:0] px [LAT];
    logic [BW-1:0] py [LAT];
    logic [ZW-1:0] pz [LAT];
    always @(posedge clock) begin
        px[0] <= rot(cordic_xi, cordic_yi, cordic_zi, 1'b0);
        py[0] <= rot(cordic_xi, cordic_yi, cordic_zi, 1'b1);
        pz[0] <= cordic_zi;
        for (int s = 1; s < LAT; s++) begin
            px[s] <= px[s-1];
            py[s] <= py[s-1];
            pz[s] <= pz[s-1];
        end
    end
    assign cordic_xo = px[LAT-1];
    assign cordic_yo = py[LAT-1];
    assign cordic_zo = pz[LAT-1];

    logic [BW-1:0] op_x [NCH];
    logic [BW-1:0] op_y [NCH];
    logic [ZW-1:0] op_z [NCH];
    int            seq  [NCH];

    always_comb begin
        req_x = '0;
        req_y = '0;
        req_z = '0;
        for (int i = 0; i < NCH; i++) begin
            req_x[i*BW +: BW] = op_x[i];
            req_y[i*BW +: BW] = op_y[i];
            req_z[i*ZW +: ZW] = op_z[i];
        end
    end

    task automatic refresh(input int ch);
        seq[ch]++;
        op_x[ch] = 16'h1000 + BW'(ch * 256) + BW'(seq[ch]);
        op_y[ch] = 16'h0100 + BW'(seq[ch] * 16);
        op_z[ch] = ZW'(ch * 24'h200000 + seq[ch] * 4369);
    endtask

    typedef struct {
        logic [CHW-1:0] chan;
        logic [BW-1:0]  x;
        logic [BW-1:0]  y;
        logic [ZW-1:0]  z;
        int             due;
    } exp_t;
    exp_t sb [$];

    // One cycle: check the grant vector, queue the expected result, then advance the operands.
    task automatic step(input logic [NCH-1:0] exp_ready);
        exp_t e;
        @(negedge clock);
        check(req_ready == exp_ready, "grant", $sformatf("%b", req_ready), $sformatf("%b", exp_ready));
        for (int ch = 0; ch < NCH; ch++) begin
            if (exp_ready[ch]) begin
                e.chan = CHW'(ch);
                e.x    = op_x[ch];
                e.y    = op_y[ch];
                e.z    = op_z[ch];
                e.due  = cyc + PIPE;
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (exp_ready[ch]) refresh(ch);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            check(busy == 1'b0, "idle_busy", $sformatf("%b", busy), "0");
            step('0);
        end
    endtask

    // Called right after a lone grant: busy profile and, for the 90 degree case, result magnitude.
    task automatic after_grant(input bit is90);
        int rx, ry;
        for (int j = 1; j <= 24; j++) begin
            if (j == 1 || j == 22) check(busy == 1'b1, "busy_high", $sformatf("%b", busy), "1");
            if (j == 23) check(busy == 1'b0, "busy_fall", $sformatf("%b", busy), "0");
            if (is90 && j == 22) begin
                rx = int'($signed(res_x));
                ry = int'($signed(res_y));
                if (ry < 0) ry = -ry;
                check(res_valid == 1'b1, "rot90_valid", $sformatf("%b", res_valid), "1");
                check(res_chan == 2'd2, "rot90_chan", $sformatf("%0d", res_chan), "2");
                check(rx >= -4 && rx <= 4, "rot90_x", $sformatf("%0d", rx), "|x|<=4");
                check(ry >= 16'h34AF - 4 && ry <= 16'h34AF + 4, "rot90_y",
                      $sformatf("%0d", ry), $sformatf("%0d+-4", 16'h34AF));
            end
            step('0);
        end
    endtask

    task automatic check_reset_state();
        check(req_ready == '0, "rst_ready", $sformatf("%b", req_ready), "0");
        check(busy == 1'b0, "rst_busy", $sformatf("%b", busy), "0");
        check(res_valid == 1'b0, "rst_res_valid", $sformatf("%b", res_valid), "0");
        check(res_chan == '0, "rst_res_chan", $sformatf("%0d", res_chan), "0");
        check(cordic_xi == '0 && cordic_yi == '0 && cordic_zi == '0, "rst_operands",
              $sformatf("%h/%h/%h", cordic_xi, cordic_yi, cordic_zi), "0/0/0");
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_checks++;
                $display("FAIL result_missing: got no strobe, expected chan %0d at cycle %0d (now %0d)",
                         sb[0].chan, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (res_valid) begin
                check(sb.size() > 0, "result_expected", "unexpected strobe", "none");
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check(res_chan == e.chan, "res_chan", $sformatf("%0d", res_chan), $sformatf("%0d", e.chan));
                    check(cyc == e.due, "res_latency", $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", e.due));
                    check(res_x == rot(e.x, e.y, e.z, 1'b0) && res_y == rot(e.x, e.y, e.z, 1'b1) && res_z == e.z,
                          "res_data", $sformatf("%h/%h/%h", res_x, res_y, res_z),
                          $sformatf("%h/%h/%h", rot(e.x, e.y, e.z, 1'b0), rot(e.x, e.y, e.z, 1'b1), e.z));
                end
            end
        end
    end

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            seq[ch] = 0;
            refresh(ch);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state();
        idle(30);

        // All four channels continuously valid: strict rotation from pointer 0.
        req_valid = 4'hF;
        for (int i = 0; i < 16; i++) step(NCH'(1 << (i % NCH)));
        req_valid = '0;
        repeat (25) step('0);

        // Lone 90 degree request on channel 2.
        op_x[2] = 16'h4000;
        op_y[2] = 16'h0000;
        op_z[2] = 24'h400000;
        req_valid = 4'b0100;
        step(4'b0100);
        req_valid = '0;
        after_grant(1'b1);
        check(cordic_xi == 16'h4000 && cordic_zi == 24'h400000, "operand_hold",
              $sformatf("%h/%h", cordic_xi, cordic_zi), "4000/400000");

        // Channel 1 alone moves the pointer to 2; then ch1+ch3 alternate starting at ch3.
        req_valid = 4'b0010;
        step(4'b0010);
        req_valid = 4'b1010;
        step(4'b1000);
        step(4'b0010);
        step(4'b1000);
        step(4'b0010);
        req_valid = '0;
        repeat (18) step('0);

        // hold while ch0 waits; the ch1/ch3 results drain during the hold window.
        req_valid = 4'b0001;
        hold = 1'b1;
        repeat (5) step('0);
        hold = 1'b0;
        step(4'b0001);
        req_valid = '0;
        after_grant(1'b0);

        // Burst, then reset with tags in flight: none of them may strobe.
        req_valid = 4'hF;
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        req_valid = '0;
        repeat (10) step('0);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state();
        idle(30);

        // Pointer is back at 0, so ch0 beats ch1.
        req_valid = 4'b0011;
        step(4'b0001);
        req_valid = '0;
        after_grant(1'b0);
        repeat (2) step('0);

        check(sb.size() == 0, "scoreboard_empty", $sformatf("%0d left", sb.size()), "0 left");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_share_arb.md
Name: cordic_share_arb

Overview:
Time-multiplexes one pipelined 24-bit-phase CORDIC rotator (16-bit I/Q, 20 stages plus an input register, fixed latency) among NCH independent requesters, such as DDC/DUC channels or NCO users.
- Round-robin arbitration with a per-channel valid/ready input handshake.
- Registers the winning operands into the CORDIC and carries the channel tag alongside the pipeline.
- Returns each result to its originating channel with a one-cycle strobe.
- Sits between the channel front-ends and the single CORDIC instance.

Parameters:
NCH, 4, number of requesters (2..8)
CHW, 2, channel tag width, equals ceil(log2(NCH))
BW, 16, x/y width
ZW, 24, phase width
CORDIC_LAT, 21, clock cycles from CORDIC input sample to valid output

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
hold  in  1  when 1, no new grants are issued; in-flight results still drain
req_valid  in  NCH  per-channel request valid
req_ready  out  NCH  per-channel grant; one-hot or zero
req_x  in  NCH*BW  flattened; channel i at [i*BW +: BW]
req_y  in  NCH*BW  flattened, same packing
req_z  in  NCH*ZW  flattened; channel i at [i*ZW +: ZW]
cordic_xi  out  BW  registered operand to the CORDIC
cordic_yi  out  BW  registered operand to the CORDIC
cordic_zi  out  ZW  registered operand to the CORDIC
cordic_xo  in  BW  CORDIC result
cordic_yo  in  BW  CORDIC result
cordic_zo  in  ZW  CORDIC result
res_valid  out  1  one-cycle result strobe
res_chan  out  CHW  channel owning the result
res_x  out  BW  result, equals cordic_xo
res_y  out  BW  result, equals cordic_yo
res_z  out  ZW  result, equals cordic_zo
busy  out  1  1 while any tag in the pipeline is valid

Behaviour:
- Reset (synchronous, active-high, clock clock):
  - rr_ptr=0, all tag-pipe valid bits 0.
  - cordic_xi/yi/zi=0; res_valid=0; res_chan=0; busy=0.
  - Any tags in flight are discarded, and CORDIC outputs for them are never strobed.
- Arbitration (combinational, same cycle):
  - If hold=0, grant the first channel i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NCH-1 back to 0.
  - req_ready = one-hot(i); all zero if no request or hold=1.
  - req_ready may depend on req_valid. A transfer occurs when req_valid[i] & req_ready[i].
  - A requester must hold req_valid and its operands stable until transfer.
- Pointer update: on transfer from channel i, rr_ptr <= (i+1) mod NCH. Otherwise unchanged.
- Issue: on transfer, cordic_xi/yi/zi <= the operands of channel i on the next edge.
  - With no transfer, the CORDIC operand registers hold their values (power), and the tag entered is invalid.
  - Throughput is 1 operation per clock across all channels.
- Tag pipe:
  - Shift register of {valid, chan}, depth 1+CORDIC_LAT.
  - Entry 0 is written on each clock with {transfer, i}.
- Result:
  - res_valid/res_chan = last tag-pipe stage.
  - res_x/y/z wired from cordic_xo/yo/zo with no extra register.
  - Accept-to-res_valid latency is exactly 1+CORDIC_LAT = 22 cycles at defaults.
  - No result backpressure: consumers must accept on the strobe.
- busy = OR of all tag-pipe valid bits.
- Fairness: with all NCH channels continuously valid, grants rotate 0,1,..,NCH-1,0,... and no channel waits more than NCH-1 cycles.
- hold asserted mid-stream: the current cycle issues no grant, in-flight tags continue, and busy falls 22 cycles after the last grant.
- Phase format: zi is unsigned full-circle, 2^24 = 360°. The CORDIC applies its own quadrant fold; this block does not alter operands.
- Amplitude: result magnitude ≈ 0.823×input (CORDIC gain/2). Compensation is the requester's responsibility.

Test Plan:
- Reset then idle 30 cycles -> req_ready=0, res_valid never 1, busy=0, cordic_*i=0.
- Single request ch2, x=0x4000, y=0, z=0x400000 (90°), accepted at cycle T -> res_valid=1 only at T+22, res_chan=2, |res_x|≤4, |res_y| within 0x34AF±4.
- All four channels valid continuously for 16 cycles -> grants 0,1,2,3 repeating; results return in the same order, 22 cycles later, one per cycle with no gaps.
- ch1 and ch3 valid, rr_ptr=2 -> ch3 granted first, then ch1, then ch3; ch0/ch2 req_ready stay 0.
- hold=1 for 5 cycles while ch0 is valid -> no grants during hold, in-flight results still strobe; ch0 granted on the first cycle hold=0.
- Reset asserted 10 cycles after a burst of 4 grants -> no res_valid ever strobed for those tags; busy=0 after reset; a new grant works normally.
